// File: rtl/can_fault_confinement.sv
// CAN fault confinement: TEC/REC bookkeeping, error-active/passive/bus-off state and bus-off recovery.
// Optional macro CAN_FC_ERR_WARN_EN builds the registered err_warning (TEC or REC >= 96) output.
`timescale 1ns/1ps
module can_fault_confinement #(
   parameter int PASSIVE_LIMIT = 128,
   parameter int BUSOFF_LIMIT  = 256,
   parameter int RECOV_SEQ     = 128,
   parameter int REC_RELOAD    = 127
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_point,
   input  logic       rx_bit,
   input  logic       bit_error,
   input  logic       stuff_error,
   input  logic       crc_error,
   input  logic       form_error,
   input  logic       ack_error,
   input  logic       tx_active,
   input  logic       in_error_flag,
   input  logic       arb_stuff_exc,
   input  logic       dom_after_flag,
   input  logic       tx_frame_ok,
   input  logic       rx_frame_ok,
   output logic [8:0] tec,
   output logic [7:0] rec,
   output logic [1:0] err_state,
   output logic       error_passive,
   output logic       bus_off,
   output logic       err_frame_req,
   output logic       err_warning
);

   typedef enum logic [1:0] {
      ST_ACTIVE  = 2'b00,
      ST_PASSIVE = 2'b01,
      ST_BUSOFF  = 2'b10
   } state_t;

   localparam logic [9:0] PASSIVE_LIM_C = 10'(PASSIVE_LIMIT);
   localparam logic [9:0] BUSOFF_LIM_C  = 10'(BUSOFF_LIMIT);
   localparam logic [7:0] RECOV_C       = 8'(RECOV_SEQ);
   localparam logic [7:0] REC_RELOAD_C  = 8'(REC_RELOAD);

   function automatic logic [8:0] tec_add8(input logic [8:0] v);
      logic [9:0] s;
      s = {1'b0, v} + 10'd8;
      tec_add8 = s[9] ? 9'h1FF : s[8:0];
   endfunction

   function automatic logic [7:0] rec_add(input logic [7:0] v, input logic [7:0] inc);
      logic [8:0] s;
      s = {1'b0, v} + {1'b0, inc};
      rec_add = s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [7:0] rec_success(input logic [7:0] v);
      if (v > 8'd127) begin
         rec_success = REC_RELOAD_C;
      end else if (v != 8'd0) begin
         rec_success = v - 8'd1;
      end else begin
         rec_success = 8'd0;
      end
   endfunction

   state_t     state_r, state_nxt_s;
   logic [8:0] tec_r, tec_nxt_s;
   logic [7:0] rec_r, rec_nxt_s;
   logic [3:0] seq_r, seq_nxt_s;
   logic [7:0] occ_r, occ_nxt_s;
   logic       passive_r, busoff_r, req_r, req_nxt_s;
   logic       err_evt_s, tx_exempt_s;

   assign err_evt_s   = bit_error | stuff_error | crc_error | form_error | ack_error;
   // A passive transmitter's ACK error and an arbitration stuff exception never cost TEC.
   assign tx_exempt_s = (arb_stuff_exc & stuff_error) |
                        ((state_r == ST_PASSIVE) & ack_error & ~bit_error);

   // Next-state, counter and recovery logic.
   always_comb begin
      tec_nxt_s   = tec_r;
      rec_nxt_s   = rec_r;
      state_nxt_s = state_r;
      seq_nxt_s   = 4'd0;
      occ_nxt_s   = 8'd0;
      req_nxt_s   = 1'b0;
      case (state_r)
         ST_BUSOFF: begin
            if (occ_r == RECOV_C) begin
               tec_nxt_s   = 9'd0;
               rec_nxt_s   = 8'd0;
               state_nxt_s = ST_ACTIVE;
            end else begin
               seq_nxt_s = seq_r;
               occ_nxt_s = occ_r;
               if (sample_point && rx_bit) begin
                  if (seq_r == 4'd10) begin
                     seq_nxt_s = 4'd0;
                     occ_nxt_s = occ_r + 8'd1;
                  end else begin
                     seq_nxt_s = seq_r + 4'd1;
                  end
               end else if (sample_point) begin
                  seq_nxt_s = 4'd0;
               end else begin
                  seq_nxt_s = seq_r;
               end
            end
         end
         ST_ACTIVE, ST_PASSIVE: begin
            req_nxt_s = err_evt_s;
            if (tx_active && err_evt_s && !tx_exempt_s) begin
               tec_nxt_s = tec_add8(tec_r);
            end else if (!err_evt_s && tx_frame_ok && (tec_r != 9'd0)) begin
               tec_nxt_s = tec_r - 9'd1;
            end else begin
               tec_nxt_s = tec_r;
            end
            // dom_after_flag dominates: a coincident error event still totals +8.
            if (!tx_active && dom_after_flag) begin
               rec_nxt_s = rec_add(rec_r, 8'd8);
            end else if (!tx_active && err_evt_s) begin
               rec_nxt_s = rec_add(rec_r, (bit_error && in_error_flag) ? 8'd8 : 8'd1);
            end else if (!err_evt_s && rx_frame_ok) begin
               rec_nxt_s = rec_success(rec_r);
            end else begin
               rec_nxt_s = rec_r;
            end
            if ({1'b0, tec_nxt_s} >= BUSOFF_LIM_C) begin
               state_nxt_s = ST_BUSOFF;
            end else if (({1'b0, tec_nxt_s} >= PASSIVE_LIM_C) ||
                         ({2'b00, rec_nxt_s} >= PASSIVE_LIM_C)) begin
               state_nxt_s = ST_PASSIVE;
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         default: begin
            state_nxt_s = ST_BUSOFF;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_ACTIVE;
         tec_r     <= 9'd0;
         rec_r     <= 8'd0;
         seq_r     <= 4'd0;
         occ_r     <= 8'd0;
         passive_r <= 1'b0;
         busoff_r  <= 1'b0;
         req_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         tec_r     <= tec_nxt_s;
         rec_r     <= rec_nxt_s;
         seq_r     <= seq_nxt_s;
         occ_r     <= occ_nxt_s;
         passive_r <= (state_nxt_s == ST_PASSIVE);
         busoff_r  <= (state_nxt_s == ST_BUSOFF);
         req_r     <= req_nxt_s;
      end
   end

`ifdef CAN_FC_ERR_WARN_EN
   logic warn_r;

   // Warning level tracks the next counter values so it moves with them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warn_r <= 1'b0;
      end else begin
         warn_r <= ({1'b0, tec_nxt_s} >= 10'd96) || ({2'b00, rec_nxt_s} >= 10'd96);
      end
   end

   assign err_warning = warn_r;
`else
   assign err_warning = 1'b0;
`endif

   assign tec           = tec_r;
   assign rec           = rec_r;
   assign err_state     = state_r;
   assign error_passive = passive_r;
   assign bus_off       = busoff_r;
   assign err_frame_req = req_r;

endmodule

// File: tb/tb_can_fault_confinement.sv
// Scoreboard bench for can_fault_confinement: directed stimulus queues expected values, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_can_fault_confinement;

   localparam logic [4:0] E_NONE  = 5'b00000;
   localparam logic [4:0] E_BIT   = 5'b10000;
   localparam logic [4:0] E_STUFF = 5'b01000;
   localparam logic [4:0] E_CRC   = 5'b00100;
   localparam logic [4:0] E_FORM  = 5'b00010;
   localparam logic [4:0] E_ACK   = 5'b00001;
   localparam logic [1:0] S_A = 2'b00;
   localparam logic [1:0] S_P = 2'b01;
   localparam logic [1:0] S_B = 2'b10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sample_point = 1'b0, rx_bit = 1'b0;
   logic bit_error = 1'b0, stuff_error = 1'b0, crc_error = 1'b0, form_error = 1'b0, ack_error = 1'b0;
   logic tx_active = 1'b0, in_error_flag = 1'b0, arb_stuff_exc = 1'b0, dom_after_flag = 1'b0;
   logic tx_frame_ok = 1'b0, rx_frame_ok = 1'b0;
   logic [8:0] tec;
   logic [7:0] rec;
   logic [1:0] err_state;
   logic       error_passive, bus_off, err_frame_req, err_warning;

   can_fault_confinement dut (
      .clk(clk), .rst(rst), .sample_point(sample_point), .rx_bit(rx_bit),
      .bit_error(bit_error), .stuff_error(stuff_error), .crc_error(crc_error),
      .form_error(form_error), .ack_error(ack_error), .tx_active(tx_active),
      .in_error_flag(in_error_flag), .arb_stuff_exc(arb_stuff_exc),
      .dom_after_flag(dom_after_flag), .tx_frame_ok(tx_frame_ok), .rx_frame_ok(rx_frame_ok),
      .tec(tec), .rec(rec), .err_state(err_state), .error_passive(error_passive),
      .bus_off(bus_off), .err_frame_req(err_frame_req), .err_warning(err_warning)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      name;
      logic [8:0] tec;
      logic [7:0] rec;
      logic [1:0] st;
      logic       req;
      logic       warn;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_cnt = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic exp_warn(input logic [8:0] t, input logic [7:0] r);
`ifdef CAN_FC_ERR_WARN_EN
      return (t >= 9'd96) || (r >= 8'd96);
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(input int cyc, input string nm, input logic [8:0] etec,
                       input logic [7:0] erec, input logic [1:0] est, input logic ereq);
      exp_t e;
      e.cyc = cyc; e.name = nm; e.tec = etec; e.rec = erec; e.st = est; e.req = ereq;
      e.warn = exp_warn(etec, erec);
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] expv);
      tests_run++;
      if (act !== expv) begin
         tests_failed++;
         $display("FAIL %s.%s actual=%0d expected=%0d (t=%0t)", nm, fld, act, expv, $time);
      end
   endtask

   // Monitor: pops every expectation due in this cycle and compares against the DUT outputs.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
         e = exp_q.pop_front();
         if (e.cyc < cyc_cnt) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s.stale actual=%0d expected=%0d", e.name, cyc_cnt, e.cyc);
         end else begin
            cmp(e.name, "tec", 16'(tec), 16'(e.tec));
            cmp(e.name, "rec", 16'(rec), 16'(e.rec));
            cmp(e.name, "err_state", 16'(err_state), 16'(e.st));
            cmp(e.name, "error_passive", 16'(error_passive), 16'(e.st == S_P));
            cmp(e.name, "bus_off", 16'(bus_off), 16'(e.st == S_B));
            cmp(e.name, "err_frame_req", 16'(err_frame_req), 16'(e.req));
            cmp(e.name, "err_warning", 16'(err_warning), 16'(e.warn));
         end
      end
   end

   task automatic step(input logic [4:0] errs, input logic txa, input logic flg, input logic arb,
                       input logic dom, input logic txok, input logic rxok, input logic sp,
                       input logic rxb, input logic chk, input string nm, input logic [8:0] etec,
                       input logic [7:0] erec, input logic [1:0] est, input logic ereq);
      {bit_error, stuff_error, crc_error, form_error, ack_error} = errs;
      tx_active = txa; in_error_flag = flg; arb_stuff_exc = arb; dom_after_flag = dom;
      tx_frame_ok = txok; rx_frame_ok = rxok; sample_point = sp; rx_bit = rxb;
      if (chk) push(cyc_cnt + 1, nm, etec, erec, est, ereq);
      @(posedge clk);
      #1;
      {bit_error, stuff_error, crc_error, form_error, ack_error} = E_NONE;
      tx_active = 1'b0; in_error_flag = 1'b0; arb_stuff_exc = 1'b0; dom_after_flag = 1'b0;
      tx_frame_ok = 1'b0; rx_frame_ok = 1'b0; sample_point = 1'b0; rx_bit = 1'b0;
   endtask

   task automatic tx_step(input logic [4:0] errs, input logic arb, input logic txok, input logic chk,
                          input string nm, input logic [8:0] etec, input logic [7:0] erec,
                          input logic [1:0] est, input logic ereq);
      step(errs, 1'b1, 1'b0, arb, 1'b0, txok, 1'b0, 1'b0, 1'b0, chk, nm, etec, erec, est, ereq);
   endtask

   task automatic rx_step(input logic [4:0] errs, input logic flg, input logic dom, input logic rxok,
                          input logic chk, input string nm, input logic [8:0] etec,
                          input logic [7:0] erec, input logic [1:0] est, input logic ereq);
      step(errs, 1'b0, flg, 1'b0, dom, 1'b0, rxok, 1'b0, 1'b0, chk, nm, etec, erec, est, ereq);
   endtask

   task automatic bit_step(input logic rxb, input logic chk, input string nm, input logic [8:0] etec,
                           input logic [7:0] erec, input logic [1:0] est);
      step(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rxb, chk, nm, etec, erec, est, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge clk);
      #1;
      step(E_STUFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "in_reset", 9'd0, 8'd0, S_A, 1'b0);
      rst = 1'b1;
      tx_step(E_NONE, 1'b0, 1'b0, 1'b1, "post_reset", 9'd0, 8'd0, S_A, 1'b0);

      for (int i = 1; i <= 16; i++)
         tx_step(E_STUFF, 1'b0, 1'b0, 1'b1, "tx_stuff", 9'(8 * i), 8'd0, (i == 16) ? S_P : S_A, 1'b1);
      tx_step(E_NONE, 1'b0, 1'b0, 1'b1, "tx_idle", 9'd128, 8'd0, S_P, 1'b0);
      tx_step(E_NONE, 1'b0, 1'b1, 1'b1, "tx_ok", 9'd127, 8'd0, S_A, 1'b0);
      tx_step(E_CRC, 1'b0, 1'b1, 1'b1, "crc_wins", 9'd135, 8'd0, S_P, 1'b1);
      tx_step(E_ACK, 1'b0, 1'b0, 1'b1, "ack_passive", 9'd135, 8'd0, S_P, 1'b1);
      tx_step(E_STUFF, 1'b1, 1'b0, 1'b1, "arb_stuff", 9'd135, 8'd0, S_P, 1'b1);
      tx_step(E_ACK | E_BIT, 1'b0, 1'b0, 1'b1, "ack_bit_once", 9'd143, 8'd0, S_P, 1'b1);
      for (int i = 1; i <= 16; i++)
         tx_step(E_NONE, 1'b0, 1'b1, (i == 16), "tx_dec", 9'(143 - i), 8'd0, S_A, 1'b0);

      for (int i = 1; i <= 130; i++)
         rx_step(E_FORM, 1'b0, 1'b0, 1'b0, 1'b1, "rx_form", 9'd127, 8'(i), (i >= 128) ? S_P : S_A, 1'b1);
      rx_step(E_NONE, 1'b0, 1'b0, 1'b1, 1'b1, "rx_reload", 9'd127, 8'd127, S_A, 1'b0);
      rx_step(E_BIT, 1'b1, 1'b0, 1'b0, 1'b1, "rx_bit_flag", 9'd127, 8'd135, S_P, 1'b1);
      rx_step(E_NONE, 1'b0, 1'b1, 1'b0, 1'b1, "dom_after", 9'd127, 8'd143, S_P, 1'b0);
      rx_step(E_FORM, 1'b0, 1'b1, 1'b0, 1'b1, "dom_and_err", 9'd127, 8'd151, S_P, 1'b1);
      rx_step(E_NONE, 1'b0, 1'b0, 1'b1, 1'b1, "rx_ok_hi", 9'd127, 8'd127, S_A, 1'b0);
      rx_step(E_NONE, 1'b0, 1'b0, 1'b1, 1'b1, "rx_ok_dec", 9'd127, 8'd126, S_A, 1'b0);
      rx_step(E_STUFF, 1'b0, 1'b0, 1'b1, 1'b1, "rx_err_wins", 9'd127, 8'd127, S_A, 1'b1);

      for (int i = 1; i <= 7; i++)
         tx_step(E_NONE, 1'b0, 1'b1, (i == 7), "tec_dn", 9'(127 - i), 8'd127, S_A, 1'b0);
      for (int i = 1; i <= 16; i++)
         tx_step(E_STUFF, 1'b0, 1'b0, (i == 16), "tec_up", 9'(120 + 8 * i), 8'd127, S_P, 1'b1);
      tx_step(E_BIT, 1'b0, 1'b0, 1'b1, "to_busoff", 9'd256, 8'd127, S_B, 1'b1);
      tx_step(E_BIT, 1'b0, 1'b0, 1'b1, "busoff_err", 9'd256, 8'd127, S_B, 1'b0);
      step(E_FORM, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "busoff_ign",
           9'd256, 8'd127, S_B, 1'b0);

      // 39 clean sequences, a dominant at bit 5 of the 40th, then 89 more clean sequences.
      repeat (39 * 11 + 4) bit_step(1'b1, 1'b0, "rec_bits", 9'd256, 8'd127, S_B);
      bit_step(1'b0, 1'b1, "dom_bit", 9'd256, 8'd127, S_B);
      for (int i = 1; i <= 88 * 11; i++)
         bit_step(1'b1, (i == 88 * 11), "busoff_hold", 9'd256, 8'd127, S_B);
      for (int i = 1; i <= 11; i++)
         bit_step(1'b1, (i == 11), "occ_full", 9'd256, 8'd127, S_B);
      tx_step(E_NONE, 1'b0, 1'b0, 1'b1, "recovered", 9'd0, 8'd0, S_A, 1'b0);

      for (int i = 1; i <= 32; i++)
         tx_step(E_STUFF, 1'b0, 1'b0, (i == 32), "busoff2", 9'(8 * i), 8'd0, S_B, 1'b1);
      repeat (50) bit_step(1'b1, 1'b0, "rec_bits2", 9'd256, 8'd0, S_B);
      #1;
      rst = 1'b0;
      push(cyc_cnt, "async_rst", 9'd0, 8'd0, S_A, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tx_step(E_NONE, 1'b0, 1'b0, 1'b1, "after_rst", 9'd0, 8'd0, S_A, 1'b0);

      for (int i = 1; i <= 96; i++)
         rx_step(E_FORM, 1'b0, 1'b0, 1'b0, (i >= 95), "warn", 9'd0, 8'(i), S_A, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
